// File: rtl/acq_mon_pkg.sv
// Shared definitions for the acquisition overrun monitor: state encoding,
// sensor bit positions and datapath widths.
package acq_mon_pkg;

  localparam int unsigned SENSOR_COUNT = 6;
  localparam int unsigned TIME_W       = 16;

  localparam int unsigned SNS_EDDY0 = 0;
  localparam int unsigned SNS_EDDY1 = 1;
  localparam int unsigned SNS_EDDY2 = 2;
  localparam int unsigned SNS_EDDY3 = 3;
  localparam int unsigned SNS_ENC   = 4;
  localparam int unsigned SNS_ADC   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_DONE = 2'd2
  } acq_state_e;

endpackage

// File: rtl/sat_counter16.sv
// Saturating up-counter with synchronous clear; an increment in the same
// cycle as a clear restarts the count at one.
module sat_counter16
  import acq_mon_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [TIME_W-1:0] count_o
);

  localparam logic [TIME_W-1:0] CNT_MAX = {TIME_W{1'b1}};

  logic [TIME_W-1:0] count_q;
  logic [TIME_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end
    if (inc_i) begin
      if (clr_i) begin
        count_d = TIME_W'(1);
      end else if (count_q != CNT_MAX) begin
        count_d = count_q + TIME_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/acq_overrun_monitor.sv
// Tracks acquisition windows opened by trigger, records completion times and
// flags overruns. Define ACQ_OVERRUN_IRQ_EN to drive the overrun_irq pulse.
module acq_overrun_monitor
  import acq_mon_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger,
  input  logic [7:0]              en_bits,
  input  logic [SENSOR_COUNT-1:0] done_bits,
  input  logic [TIME_W-1:0]       count_time,
  input  logic                    clear,
  output logic [1:0]              state,
  output logic                    overrun_flag,
  output logic [TIME_W-1:0]       overrun_count,
  output logic [SENSOR_COUNT-1:0] missing_bits,
  output logic [TIME_W-1:0]       last_acq_time,
  output logic [TIME_W-1:0]       max_acq_time,
  output logic                    overrun_irq
);

  acq_state_e              state_q, state_d;
  logic [SENSOR_COUNT-1:0] mask_q, mask_d;
  logic                    flag_q, flag_d;
  logic [SENSOR_COUNT-1:0] miss_q, miss_d;
  logic [TIME_W-1:0]       last_q, last_d;
  logic [TIME_W-1:0]       max_q, max_d;

  logic [SENSOR_COUNT-1:0] snap_c;
  logic [SENSOR_COUNT-1:0] pending_c;
  logic                    all_done_c;
  logic                    complete_c;
  logic                    overrun_c;
  logic                    unused_en;

  assign snap_c     = en_bits[SENSOR_COUNT-1:0];
  assign unused_en  = ^en_bits[7:SENSOR_COUNT];
  assign pending_c  = mask_q & ~done_bits;
  assign all_done_c = (pending_c == '0);
  // Only meaningful once in ACQ, so completion can never fire in the trigger cycle.
  assign complete_c = (state_q == ST_ACQ) && all_done_c;
  assign overrun_c  = (state_q == ST_ACQ) && trigger && !all_done_c;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    flag_d  = flag_q;
    miss_d  = miss_q;
    last_d  = last_q;
    max_d   = max_q;

    if (clear) begin
      flag_d = 1'b0;
      miss_d = '0;
      max_d  = '0;
    end

    if (complete_c) begin
      last_d = count_time;
      if (!clear && (count_time > max_q)) begin
        max_d = count_time;
      end
      state_d = ST_DONE;
    end

    // Overrun wins over a simultaneous clear.
    if (overrun_c) begin
      flag_d = 1'b1;
      miss_d = pending_c;
    end

    if (trigger) begin
      mask_d  = snap_c;
      state_d = (snap_c == '0) ? ST_IDLE : ST_ACQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      flag_q  <= 1'b0;
      miss_q  <= '0;
      last_q  <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      flag_q  <= flag_d;
      miss_q  <= miss_d;
      last_q  <= last_d;
      max_q   <= max_d;
    end
  end

  sat_counter16 u_ovr_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (overrun_c),
    .clr_i   (clear),
    .count_o (overrun_count)
  );

`ifdef ACQ_OVERRUN_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= overrun_c;
    end
  end

  assign overrun_irq = irq_q;
`else
  assign overrun_irq = 1'b0;
`endif

  assign state         = 2'(state_q);
  assign overrun_flag  = flag_q;
  assign missing_bits  = miss_q;
  assign last_acq_time = last_q;
  assign max_acq_time  = max_q;

endmodule

// File: tb/tb_acq_overrun_monitor.sv
// Directed scoreboard bench for acq_overrun_monitor; expectations are tagged
// with the cycle whose rising edge should produce them.
module tb_acq_overrun_monitor;

`ifdef ACQ_OVERRUN_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic [7:0]  en_bits;
  logic [5:0]  done_bits;
  logic [15:0] count_time;
  logic        clear;
  logic [1:0]  state;
  logic        overrun_flag;
  logic [15:0] overrun_count;
  logic [5:0]  missing_bits;
  logic [15:0] last_acq_time;
  logic [15:0] max_acq_time;
  logic        overrun_irq;

  acq_overrun_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .trigger       (trigger),
    .en_bits       (en_bits),
    .done_bits     (done_bits),
    .count_time    (count_time),
    .clear         (clear),
    .state         (state),
    .overrun_flag  (overrun_flag),
    .overrun_count (overrun_count),
    .missing_bits  (missing_bits),
    .last_acq_time (last_acq_time),
    .max_acq_time  (max_acq_time),
    .overrun_irq   (overrun_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [1:0]  st;
    logic        flag;
    logic [15:0] cnt;
    logic [5:0]  miss;
    logic [15:0] last;
    logic [15:0] mx;
    logic        irq;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          stim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectation for the outputs after the next rising edge.
  task automatic expect_out(input string name, input logic [1:0] st, input logic flag,
                            input logic [15:0] cnt, input logic [5:0] miss,
                            input logic [15:0] last, input logic [15:0] mx, input logic irq);
    exp_t e;
    e.cyc = cyc + 1; e.name = name; e.st = st; e.flag = flag; e.cnt = cnt;
    e.miss = miss; e.last = last; e.mx = mx; e.irq = irq;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    trigger = 1'b0;
    clear   = 1'b0;
    rst     = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || state !== e.st || overrun_flag !== e.flag ||
          overrun_count !== e.cnt || missing_bits !== e.miss ||
          last_acq_time !== e.last || max_acq_time !== e.mx || overrun_irq !== e.irq) begin
        errors++;
        $display("FAIL %s cyc=%0d/%0d got st=%0d flag=%b cnt=%h miss=%h last=%h max=%h irq=%b required st=%0d flag=%b cnt=%h miss=%h last=%h max=%h irq=%b",
                 e.name, cyc, e.cyc, state, overrun_flag, overrun_count, missing_bits,
                 last_acq_time, max_acq_time, overrun_irq,
                 e.st, e.flag, e.cnt, e.miss, e.last, e.mx, e.irq);
      end
    end
    if (stim_done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; trigger = 1'b0; clear = 1'b0;
    en_bits = 8'h00; done_bits = 6'h00; count_time = 16'h0000;
    tick();
    rst = 1'b1;
    expect_out("reset", S_IDLE, 0, 16'h0, 6'h0, 16'h0, 16'h0, 0);
    tick();

    // Normal completion
    en_bits = 8'h21; trigger = 1'b1;
    expect_out("start", S_ACQ, 0, 16'h0, 6'h0, 16'h0, 16'h0, 0);
    tick();
    count_time = 16'h0040; done_bits = 6'h21;
    expect_out("complete", S_DONE, 0, 16'h0, 6'h0, 16'h0040, 16'h0040, 0);
    tick();

    // Overrun
    en_bits = 8'h0F; done_bits = 6'h05; count_time = 16'h0000; trigger = 1'b1;
    expect_out("ovr_start", S_ACQ, 0, 16'h0, 6'h0, 16'h0040, 16'h0040, 0);
    tick();
    trigger = 1'b1;
    expect_out("overrun", S_ACQ, 1, 16'h1, 6'h0A, 16'h0040, 16'h0040, IRQ);
    tick();
    expect_out("irq_drop", S_ACQ, 1, 16'h1, 6'h0A, 16'h0040, 16'h0040, 0);
    tick();

    // Trigger coincident with completion
    done_bits = 6'h0F; count_time = 16'h0100; trigger = 1'b1;
    expect_out("simul", S_ACQ, 1, 16'h1, 6'h0A, 16'h0100, 16'h0100, 0);
    tick();
    done_bits = 6'h00;
    expect_out("simul_hold", S_ACQ, 1, 16'h1, 6'h0A, 16'h0100, 16'h0100, 0);
    tick();

    // Clear leaves state and last time alone
    clear = 1'b1;
    expect_out("clear", S_ACQ, 0, 16'h0, 6'h0, 16'h0100, 16'h0, 0);
    tick();

    // Max hold, no completion in trigger cycle, zero enables
    done_bits = 6'h0F; count_time = 16'h0080;
    expect_out("cmp_80", S_DONE, 0, 16'h0, 6'h0, 16'h0080, 16'h0080, 0);
    tick();
    count_time = 16'h0000; trigger = 1'b1;
    expect_out("trig_done_hi", S_ACQ, 0, 16'h0, 6'h0, 16'h0080, 16'h0080, 0);
    tick();
    count_time = 16'h0030;
    expect_out("max_hold", S_DONE, 0, 16'h0, 6'h0, 16'h0030, 16'h0080, 0);
    tick();
    en_bits = 8'hC0; trigger = 1'b1;
    expect_out("zero_en", S_IDLE, 0, 16'h0, 6'h0, 16'h0030, 16'h0080, 0);
    tick();

    // Reset in ACQ after an overrun
    en_bits = 8'h01; done_bits = 6'h00; count_time = 16'h0000; trigger = 1'b1;
    expect_out("acq_again", S_ACQ, 0, 16'h0, 6'h0, 16'h0030, 16'h0080, 0);
    tick();
    trigger = 1'b1;
    expect_out("ovr_pre_rst", S_ACQ, 1, 16'h1, 6'h01, 16'h0030, 16'h0080, IRQ);
    tick();
    rst = 1'b1; trigger = 1'b1; clear = 1'b1;
    expect_out("rst_acq", S_IDLE, 0, 16'h0, 6'h0, 16'h0, 16'h0, 0);
    tick();
    done_bits = 6'h01;
    expect_out("post_rst_idle", S_IDLE, 0, 16'h0, 6'h0, 16'h0, 16'h0, 0);
    tick();

    // Saturation over 65537 overruns
    done_bits = 6'h00; trigger = 1'b1;
    expect_out("sat_start", S_ACQ, 0, 16'h0, 6'h0, 16'h0, 16'h0, 0);
    tick();
    for (int i = 1; i <= 65537; i++) begin
      trigger = 1'b1;
      if (i == 1 || i == 65534 || i == 65535 || i == 65537) begin
        expect_out($sformatf("sat_%0d", i), S_ACQ, 1,
                   (i >= 65535) ? 16'hFFFF : 16'(i), 6'h01, 16'h0, 16'h0, IRQ);
      end
      tick();
    end

    // Overrun beats a simultaneous clear
    trigger = 1'b1; clear = 1'b1;
    expect_out("clr_ovr", S_ACQ, 1, 16'h1, 6'h01, 16'h0, 16'h0, IRQ);
    tick();
    clear = 1'b1;
    expect_out("clr_only", S_ACQ, 0, 16'h0, 6'h0, 16'h0, 16'h0, 0);
    tick();

    @(posedge clk);
    #1;
    stim_done = 1'b1;
  end

endmodule

// File: doc/acq_overrun_monitor.md
ACQ_OVERRUN_MONITOR -- requirements
Module: acq_overrun_monitor

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port trigger, input, 1 bit: one-cycle pulse that starts an acquisition window.
REQ-004 SHALL have port en_bits, input, 8 bits: sensor enables; [0..3] eddy 0..3, [4] encoder, [5] ADC, [7:6] ignored.
REQ-005 SHALL have port done_bits, input, 6 bits: level done flags, same bit order as en_bits[5:0].
REQ-006 SHALL have port count_time, input, 16 bits: free-running cycle count since the last trigger.
REQ-007 SHALL have port clear, input, 1 bit: software clear of the sticky status and statistics.
REQ-008 SHALL have port state, output, 2 bits: FSM state; IDLE=0, ACQ=1, DONE=2.
REQ-009 SHALL have port overrun_flag, output, 1 bit: sticky overrun indicator.
REQ-010 SHALL have port overrun_count, output, 16 bits: saturating overrun counter.
REQ-011 SHALL have port missing_bits, output, 6 bits: enabled sensors not done at the last overrun.
REQ-012 SHALL have port last_acq_time, output, 16 bits: count_time at the most recent completion.
REQ-013 SHALL have port max_acq_time, output, 16 bits: largest last_acq_time since reset or clear.
REQ-014 SHALL have port overrun_irq, output, 1 bit: overrun interrupt pulse.

Function
REQ-015 SHALL snapshot en_bits[5:0] into mask on every trigger.
- If the snapshot is zero: go to IDLE and record nothing.
- Otherwise: go to ACQ.
REQ-016 SHALL define all_done = (mask & ~done_bits) == 0.
- Evaluated only in ACQ, from the cycle after the trigger onward.
- Completion is never detected in the trigger cycle itself.
REQ-017 SHALL handle ACQ with all_done and no trigger as follows:
- last_acq_time <= count_time.
- max_acq_time <= count_time only if count_time is strictly greater.
- Go to DONE.
REQ-018 SHALL handle a trigger in ACQ with all_done false as an overrun:
- overrun_flag <= 1.
- overrun_count increments, saturating at 0xFFFF.
- missing_bits <= mask & ~done_bits.
- Re-snapshot mask per REQ-015.
REQ-019 SHALL handle a trigger in ACQ with all_done true in the same cycle as follows:
- Record the completion per REQ-017.
- No overrun.
- Re-snapshot per REQ-015.
REQ-020 SHALL treat a trigger in IDLE or DONE as a normal start, with no overrun.
REQ-021 SHALL make clear zero overrun_flag, overrun_count, missing_bits and max_acq_time on the next edge.
- clear SHALL NOT affect state, mask or last_acq_time.
REQ-022 SHALL give an overrun precedence over a clear in the same cycle.
- Result: flag=1, count=1, missing_bits as per REQ-018.
REQ-023 SHALL register every output, with one-cycle latency from the causing input edge.

Reset
REQ-024 SHALL, while rst=1, force the following values:
- state=IDLE, mask=0.
- All counters, times, flags, missing_bits and overrun_irq = 0.
REQ-025 SHALL give rst priority over trigger and clear.
- Reset during ACQ SHALL abandon the window with no statistics update.

Configuration
REQ-026 SHALL, with macro ACQ_OVERRUN_IRQ_EN defined, pulse overrun_irq high for exactly one cycle on each overrun.
- The pulse coincides with overrun_flag being set.
- It repeats on every overrun, including saturated ones.
REQ-027 SHALL, without ACQ_OVERRUN_IRQ_EN, keep the overrun_irq port present and tie it to 0.
- All other behaviour is unchanged.

Structure
REQ-028 SHALL place the following in shared package acq_mon_pkg:
- the state encoding;
- SENSOR_COUNT=6;
- sensor bit-index constants;
- TIME_W=16.
REQ-029 SHALL instantiate sub-module sat_counter16 for overrun_count, with increment, clear and saturate behaviour.

Verification
REQ-030 SHALL verify normal completion:
- Stimulus: en_bits=0x21, trigger; done_bits=0x21 when count_time=0x0040.
- Response: last=max=0x0040, state=DONE, overrun_flag=0.
REQ-031 SHALL verify overrun:
- Stimulus: en_bits=0x0F, done_bits=0x05, second trigger.
- Response: overrun_count=1, missing_bits=0x0A, state=ACQ, overrun_irq one cycle (macro on).
REQ-032 SHALL verify the simultaneous case:
- Stimulus: trigger in the same cycle that all_done rises, count_time=0x0100.
- Response: last=0x0100, no overrun, state=ACQ.
REQ-033 SHALL verify saturation and clear:
- Stimulus: 65537 overruns.
- Response: count=0xFFFF.
- Then clear plus overrun in the same cycle: count=1, flag=1.
REQ-034 SHALL verify the maximum hold and the zero-enable case:
- Stimulus: completions at 0x0080, then 0x0030.
- Response: max=0x0080, last=0x0030.
- Trigger with en_bits=0xC0: state=IDLE.
REQ-035 SHALL verify reset in ACQ:
- Stimulus: rst=1 for one cycle in ACQ.
- Response: all outputs 0 next edge, state=IDLE.
